// File: rtl/fuzzy_frame_loader_pkg.sv
// Shared types and constants for the fuzzy engine input stage.
// Frame FSM states, error codes and default header byte.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        HOLD    = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SYNC    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fuzzy_frame_loader_strobe_sync.sv
// Pad strobe synchroniser with rising-edge detect.
// Emits a single-cycle stb per strobe, however long ss_raw stays high.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_raw,
    output logic stb
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= ss_raw;
            sync <= meta;
            prev <= sync;
        end
    end

    assign stb = sync & ~prev;

endmodule

// File: rtl/fuzzy_frame_loader.sv
// Frame loader: sync byte + NUM_INPUTS operand bytes from a strobed pad bus,
// handed to the fuzzifier as one atomic operand word under valid/ready.
module fuzzy_frame_loader
    import fuzzy_pkg::*;
#(
    parameter int                NUM_INPUTS  = 2,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_DEFAULT),
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ss,
    input  logic [DATA_W-1:0]            data_bus,
    output logic [NUM_INPUTS*DATA_W-1:0] operands,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         busy,
    output logic                         frame_err,
    output logic [1:0]                   err_code
);

    localparam int IW = idx_width(NUM_INPUTS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT_CYC - 1);

    logic stb;

    state_t                                state_q, state_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [TW-1:0]                         timer_q, timer_d;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]     shadow_q, shadow_d;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]     ops_q, ops_d;
    logic                                  fv_q, fv_d;
    logic                                  err_q, err_d;
    err_t                                  code_q, code_d;
    logic                                  handshake;
    logic                                  is_sync;

    strobe_sync u_strobe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ss_raw (ss),
        .stb    (stb)
    );

    assign handshake = fv_q & frame_ready;
    assign is_sync   = (data_bus == SYNC_BYTE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        ops_d    = ops_q;
        fv_d     = fv_q;
        err_d    = 1'b0;
        code_d   = code_q;
        unique case (state_q)
            IDLE: begin
                if (stb) begin
                    if (is_sync) begin
                        state_d = COLLECT;
                        idx_d   = '0;
                        timer_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_SYNC;
                    end
                end
            end
            COLLECT: begin
                if (stb) begin
                    shadow_d[idx_q] = data_bus;
                    timer_d         = '0;
                    if (idx_q == LAST_IDX) begin
                        ops_d   = shadow_d;
                        fv_d    = 1'b1;
                        idx_d   = '0;
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timer_q >= TLAST) begin
                    err_d    = 1'b1;
                    code_d   = ERR_TIMEOUT;
                    shadow_d = '0;
                    idx_d    = '0;
                    timer_d  = '0;
                    state_d  = IDLE;
                end else if (timer_q != TMAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (handshake) begin
                    fv_d    = 1'b0;
                    state_d = IDLE;
                    // A strobe coinciding with the handshake starts the next frame
                    if (stb) begin
                        if (is_sync) begin
                            state_d = COLLECT;
                            idx_d   = '0;
                            timer_d = '0;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_SYNC;
                        end
                    end
                end else if (stb) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            shadow_q <= '0;
            ops_q    <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
            ops_q    <= ops_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign operands    = ops_q;
    assign frame_valid = fv_q;
    assign busy        = (state_q != IDLE);
    assign frame_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_fuzzy_frame_loader.sv
// Directed bench for fuzzy_frame_loader with hand-computed expectations.
// Timeout shortened so a long strobe and a timeout both fit one run.
module tb_fuzzy_frame_loader;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss;
    logic [7:0]  data_bus;
    logic [15:0] operands;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic        frame_err;
    logic [1:0]  err_code;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_seen = 0;

    fuzzy_frame_loader #(
        .NUM_INPUTS  (2),
        .DATA_W      (8),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ss          (ss),
        .data_bus    (data_bus),
        .operands    (operands),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap,
                             output logic [3:0] fvs);
        @(negedge clk);
        data_bus = b;
        ss = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fvs[i] = frame_valid;
        end
        ss = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ss = 1'b0;
        data_bus = 8'h00;
        frame_ready = 1'b1;
        #12;
        total_cnt++;
        if (operands !== 16'h0000)
            $display("FAIL reset_operands got %h want 0000", operands);
        else pass_cnt++;
        total_cnt++;
        if ({frame_valid, busy, frame_err} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {frame_valid, busy, frame_err});
        else pass_cnt++;
        total_cnt++;
        if (err_code !== 2'b00)
            $display("FAIL reset_err_code got %b want 00", err_code);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        logic [3:0] fvs;
        int e0;
        e0 = err_seen;
        frame_ready = 1'b1;
        send_byte(8'hA5, 6, fvs);
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL nominal_busy got %b want 1", busy);
        else pass_cnt++;
        send_byte(8'h3C, 6, fvs);
        send_byte(8'hC8, 6, fvs);
        total_cnt++;
        if (fvs !== 4'b0100)
            $display("FAIL nominal_valid_timing got %b want 0100", fvs);
        else pass_cnt++;
        total_cnt++;
        if (operands !== 16'hC83C)
            $display("FAIL nominal_operands got %h want c83c", operands);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL nominal_busy_end got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (err_seen !== e0)
            $display("FAIL nominal_no_err got %0d want %0d", err_seen, e0);
        else pass_cnt++;
    endtask

    task automatic test_bad_sync();
        logic [3:0] fvs;
        int e0;
        e0 = err_seen;
        send_byte(8'h12, 4, fvs);
        total_cnt++;
        if (err_seen !== e0 + 1)
            $display("FAIL badsync_pulses got %0d want %0d", err_seen, e0 + 1);
        else pass_cnt++;
        total_cnt++;
        if (err_code !== 2'b01)
            $display("FAIL badsync_code got %b want 01", err_code);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || operands !== 16'hC83C)
            $display("FAIL badsync_state got busy=%b ops=%h want 0/c83c",
                     busy, operands);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [3:0] fvs;
        int n;
        send_byte(8'hA5, 2, fvs);
        send_byte(8'h10, 0, fvs);
        n = 0;
        while (n < 3 * TO) begin
            @(negedge clk);
            n++;
            if (frame_err === 1'b1) break;
        end
        total_cnt++;
        if (n !== TO - 1)
            $display("FAIL timeout_latency got %0d want %0d", n, TO - 1);
        else pass_cnt++;
        total_cnt++;
        if (err_code !== 2'b10)
            $display("FAIL timeout_code got %b want 10", err_code);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || operands !== 16'hC83C)
            $display("FAIL timeout_state got busy=%b ops=%h want 0/c83c",
                     busy, operands);
        else pass_cnt++;
        send_byte(8'hA5, 3, fvs);
        send_byte(8'h01, 3, fvs);
        send_byte(8'h02, 3, fvs);
        total_cnt++;
        if (operands !== 16'h0201)
            $display("FAIL timeout_next_frame got %h want 0201", operands);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [3:0] fvs;
        int e0;
        frame_ready = 1'b0;
        send_byte(8'hA5, 3, fvs);
        send_byte(8'h11, 3, fvs);
        send_byte(8'h22, 3, fvs);
        total_cnt++;
        if (frame_valid !== 1'b1 || operands !== 16'h2211)
            $display("FAIL overrun_hold got fv=%b ops=%h want 1/2211",
                     frame_valid, operands);
        else pass_cnt++;
        e0 = err_seen;
        send_byte(8'h55, 3, fvs);
        total_cnt++;
        if (err_seen !== e0 + 1 || err_code !== 2'b11)
            $display("FAIL overrun_err got n=%0d code=%b want %0d/11",
                     err_seen, err_code, e0 + 1);
        else pass_cnt++;
        total_cnt++;
        if (frame_valid !== 1'b1 || operands !== 16'h2211 || busy !== 1'b1)
            $display("FAIL overrun_keep got fv=%b ops=%h busy=%b want 1/2211/1",
                     frame_valid, operands, busy);
        else pass_cnt++;
        frame_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (frame_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL overrun_release got fv=%b busy=%b want 0/0",
                     frame_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (operands !== 16'h2211)
            $display("FAIL overrun_ops_after got %h want 2211", operands);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] fvs;
        int e0;
        frame_ready = 1'b0;
        send_byte(8'hA5, 3, fvs);
        send_byte(8'h33, 3, fvs);
        send_byte(8'h44, 3, fvs);
        e0 = err_seen;
        @(negedge clk);
        data_bus = 8'hA5;
        ss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (frame_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL collide_state got fv=%b busy=%b want 0/1",
                     frame_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (operands !== 16'h4433)
            $display("FAIL collide_ops got %h want 4433", operands);
        else pass_cnt++;
        @(negedge clk);
        ss = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h7F, 3, fvs);
        send_byte(8'h80, 3, fvs);
        total_cnt++;
        if (operands !== 16'h807F)
            $display("FAIL collide_next_frame got %h want 807f", operands);
        else pass_cnt++;
        total_cnt++;
        if (err_seen !== e0)
            $display("FAIL collide_no_err got %0d want %0d", err_seen, e0);
        else pass_cnt++;
    endtask

    task automatic test_reset_long_strobe();
        logic [3:0] fvs;
        int e0;
        send_byte(8'h01, 3, fvs);
        send_byte(8'hA5, 3, fvs);
        send_byte(8'h44, 3, fvs);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (operands !== 16'h0000 || err_code !== 2'b00)
            $display("FAIL midreset_data got ops=%h code=%b want 0000/00",
                     operands, err_code);
        else pass_cnt++;
        total_cnt++;
        if ({frame_valid, busy, frame_err} !== 3'b000)
            $display("FAIL midreset_flags got %b want 000",
                     {frame_valid, busy, frame_err});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e0 = err_seen;
        data_bus = 8'hA5;
        ss = 1'b1;
        repeat (50) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || err_seen !== e0)
            $display("FAIL long_strobe got busy=%b errs=%0d want 1/%0d",
                     busy, err_seen, e0);
        else pass_cnt++;
        ss = 1'b0;
        @(negedge clk);
        send_byte(8'h01, 3, fvs);
        send_byte(8'h02, 3, fvs);
        total_cnt++;
        if (operands !== 16'h0201 || err_seen !== e0)
            $display("FAIL long_strobe_frame got ops=%h errs=%0d want 0201/%0d",
                     operands, err_seen, e0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_sync();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_long_strobe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fuzzy_frame_loader.md
Name: fuzzy_frame_loader

Overview:
Input stage directly upstream of the fuzzy risk engine. It synchronises the raw `ss` byte-strobe from the pad and captures bytes from `data_bus` on each strobe rising edge. It assembles a framed packet of crisp operands (sync byte followed by NUM_INPUTS data bytes). The packet is presented to the fuzzifier with a valid/ready handshake, and every operand is updated atomically.

Parameters:
NUM_INPUTS, 2, number of crisp operand bytes per frame (range 1..8)
DATA_W, 8, operand and bus width
SYNC_BYTE, 8'hA5, header byte that must open every frame
TIMEOUT_CYC, 255, max clk cycles allowed between strobes inside a frame (range 1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ss  in  1  raw byte strobe from pad, asynchronous to clk
data_bus  in  DATA_W  byte presented with ss; stable while ss high
operands  out  NUM_INPUTS*DATA_W  assembled frame; byte i at bits [i*DATA_W +: DATA_W]
frame_valid  out  1  operands hold a new frame not yet consumed
frame_ready  in  1  downstream engine accepts the frame
busy  out  1  high while in COLLECT or HOLD
frame_err  out  1  one-cycle error pulse
err_code  out  2  cause of last error: 01 bad sync, 10 timeout, 11 overrun; held until next error

Behaviour:
- Reset (async assert, sync release): state IDLE; operands=0, frame_valid=0, busy=0, frame_err=0, err_code=00; synchroniser flops, shadow registers, index and timeout counter all 0.
- Strobe path:
  - ss passes through a 2-flop synchroniser and then a rising-edge detector, giving a one-cycle internal `stb`.
  - If ss is first sampled high at edge k, then `stb` is high in the cycle after edge k+1, and data_bus is captured at edge k+2.
  - ss high for many cycles yields exactly one `stb`.
  - data_bus must be stable from ss rise through 4 clk cycles afterwards.
- IDLE:
  - stb with data_bus==SYNC_BYTE: go to COLLECT, idx=0, timer cleared.
  - stb with any other byte: byte dropped, frame_err pulse, err_code=01, stay IDLE.
- COLLECT:
  - Each stb writes the byte to shadow[idx], idx++, timer cleared.
  - Timer counts every cycle with no stb. When it reaches TIMEOUT_CYC: frame_err pulse, err_code=10, shadow discarded, operands unchanged, return to IDLE.
  - On the stb that stores byte NUM_INPUTS-1, at the same edge: all shadow bytes plus the current byte are copied to operands, frame_valid<=1, state HOLD.
  - A SYNC_BYTE value inside COLLECT is ordinary data.
- HOLD:
  - frame_valid stays high until a cycle where frame_valid & frame_ready; the next state is then IDLE and frame_valid<=0.
  - stb in HOLD without a handshake: byte dropped, frame_err pulse, err_code=11.
  - stb in the same cycle as the handshake: the byte is treated as an IDLE strobe, so a sync byte goes straight to COLLECT (back-to-back frames with no error).
- operands change only on frame completion; they stay stable during and after the handshake until the next completed frame.
- frame_ready is ignored outside HOLD.
- busy = (state != IDLE), registered with the state.
- Timeout counter width is clog2(TIMEOUT_CYC+1) and saturates; there is no wrap.
- Async reset mid-frame: partial frame is lost, all outputs return to reset values immediately.

Decomposition:
- Package fuzzy_pkg holds:
  - state typedef {IDLE, COLLECT, HOLD}
  - err_code typedef {ERR_NONE=00, ERR_SYNC=01, ERR_TIMEOUT=10, ERR_OVERRUN=11}
  - SYNC_BYTE default constant
- One sub-module, strobe_sync: clk, rst_n, ss_raw in, stb out. It contains the 2-flop synchroniser plus the rising-edge detector and is reusable for other pad strobes.
- Frame FSM, shadow registers and timer stay in fuzzy_frame_loader.

Test Plan:
- Nominal frame, NUM_INPUTS=2, frame_ready held 1: strobes 0xA5, 0x3C, 0xC8 spaced 10 cycles -> operands=16'hC83C, frame_valid high exactly 1 cycle, starting 3 clk edges after the third ss rise; busy high from the sync byte until the handshake; no frame_err.
- Bad sync: strobe 0x12 in IDLE -> one-cycle frame_err, err_code=01, busy stays 0, operands unchanged.
- Timeout, TIMEOUT_CYC=20: 0xA5, 0x10, then silence 25 cycles -> frame_err after 20 idle cycles, err_code=10, state IDLE. A following full frame 0xA5, 0x01, 0x02 then yields operands=16'h0201.
- Backpressure/overrun: complete frame with frame_ready=0, then strobe 0x55 -> frame_valid stays 1, operands unchanged, frame_err with err_code=11. Raising frame_ready clears frame_valid next cycle.
- Handshake collision: in HOLD, ss strobe of 0xA5 aligned to the stb cycle with frame_ready=1 -> no error, busy stays 1, state COLLECT. The next two bytes 0x7F, 0x80 complete operands=16'h807F.
- Reset mid-frame plus long strobe: assert rst_n=0 after 0xA5, 0x44 -> all outputs 0 asynchronously. After release, ss held high 50 cycles with 0xA5 counts as one strobe only (idx=0 in COLLECT).
